// File: rtl/float32_adder.sv
`timescale 1ns/1ps
// IEEE-754 binary32 adder, round-to-nearest-even, subnormals flushed to zero.
// Latency 2 clocks after the sampling edge, one pair per cycle, no backpressure.
module float32_adder (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    output logic [31:0] result
);
    localparam logic [31:0] QNAN = 32'h7FC00000;

    // Operand capture
    logic        in_vld_q, in_vld_d;
    logic [31:0] a_q, a_d, b_q, b_d;

    // Unpack/align stage registers
    logic        s1_vld_q, s1_vld_d;
    logic        s1_sign_q, s1_sign_d;
    logic        s1_sub_q, s1_sub_d;
    logic [7:0]  s1_exp_q, s1_exp_d;
    logic [23:0] s1_man_l_q, s1_man_l_d;
    logic [26:0] s1_man_s_q, s1_man_s_d;
    logic        s1_spec_q, s1_spec_d;
    logic [31:0] s1_spec_res_q, s1_spec_res_d;

    logic        out_valid_q, out_valid_d;
    logic [31:0] result_q, result_d;

    logic [7:0]  ea, eb, exp_s, sh;
    logic [23:0] ma, mb, man_s;
    logic [26:0] ext, shifted;
    logic        a_ge, nan_a, nan_b, inf_a, inf_b, lost;

    always_comb begin
        in_vld_d = in_valid;
        a_d      = a;
        b_d      = b;

        ea = a_q[30:23];
        eb = b_q[30:23];
        ma = (ea != 8'd0) ? {1'b1, a_q[22:0]} : 24'd0;
        mb = (eb != 8'd0) ? {1'b1, b_q[22:0]} : 24'd0;
        a_ge = {ea, ma} >= {eb, mb};

        s1_vld_d   = in_vld_q;
        s1_sign_d  = a_ge ? a_q[31] : b_q[31];
        s1_sub_d   = a_q[31] ^ b_q[31];
        s1_exp_d   = a_ge ? ea : eb;
        s1_man_l_d = a_ge ? ma : mb;
        exp_s      = a_ge ? eb : ea;
        man_s      = a_ge ? mb : ma;
        sh         = s1_exp_d - exp_s;

        ext     = {man_s, 3'b000};
        shifted = 27'd0;
        lost    = 1'b0;
        if (sh >= 8'd26) begin
            s1_man_s_d = {26'd0, |man_s};
        end else begin
            shifted    = ext >> sh;
            lost       = |(ext << (8'd27 - sh));
            s1_man_s_d = {shifted[26:1], shifted[0] | lost};
        end

        nan_a = (&ea) && (|a_q[22:0]);
        nan_b = (&eb) && (|b_q[22:0]);
        inf_a = (&ea) && !(|a_q[22:0]);
        inf_b = (&eb) && !(|b_q[22:0]);
        s1_spec_d = nan_a | nan_b | inf_a | inf_b;
        if (nan_a || nan_b || (inf_a && inf_b && (a_q[31] != b_q[31])))
            s1_spec_res_d = QNAN;
        else if (inf_a)
            s1_spec_res_d = a_q;
        else
            s1_spec_res_d = b_q;
    end

    logic [27:0]       sum;
    logic [26:0]       man_ext, diff, norm;
    logic [4:0]        lz;
    logic              found, is_zero, inc;
    logic signed [9:0] exp_n, exp_r;
    logic [24:0]       rnd;
    logic [22:0]       frac;
    logic [31:0]       res;

    always_comb begin
        man_ext = {s1_man_l_q, 3'b000};
        exp_n   = $signed({2'b00, s1_exp_q});
        sum     = 28'd0;
        diff    = 27'd0;
        lz      = 5'd0;
        found   = 1'b0;
        if (!s1_sub_q) begin
            sum     = {1'b0, man_ext} + {1'b0, s1_man_s_q};
            is_zero = (sum == 28'd0);
            if (sum[27]) begin
                norm  = {sum[27:2], sum[1] | sum[0]};
                exp_n = exp_n + 10'sd1;
            end else begin
                norm = sum[26:0];
            end
        end else begin
            // L is never smaller than the aligned operand, so no borrow
            diff    = man_ext - s1_man_s_q;
            is_zero = (diff == 27'd0);
            for (int i = 26; i >= 0; i--) begin
                if (!found) begin
                    if (diff[i]) found = 1'b1;
                    else         lz = lz + 5'd1;
                end
            end
            norm  = diff << lz;
            exp_n = exp_n - $signed({5'd0, lz});
        end

        inc   = norm[2] & (norm[1] | norm[0] | norm[3]);
        rnd   = {1'b0, norm[26:3]} + {24'd0, inc};
        exp_r = rnd[24] ? exp_n + 10'sd1 : exp_n;
        frac  = rnd[24] ? rnd[23:1] : rnd[22:0];

        if (s1_spec_q)
            res = s1_spec_res_q;
        else if (is_zero)
            res = {s1_sub_q ? 1'b0 : s1_sign_q, 31'd0};
        else if (exp_n <= 10'sd0)
            res = {s1_sign_q, 31'd0};
        else if (exp_r >= 10'sd255)
            res = {s1_sign_q, 8'hFF, 23'd0};
        else
            res = {s1_sign_q, exp_r[7:0], frac};

        out_valid_d = s1_vld_q;
        result_d    = s1_vld_q ? res : result_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_vld_q      <= 1'b0;
            a_q           <= 32'd0;
            b_q           <= 32'd0;
            s1_vld_q      <= 1'b0;
            s1_sign_q     <= 1'b0;
            s1_sub_q      <= 1'b0;
            s1_exp_q      <= 8'd0;
            s1_man_l_q    <= 24'd0;
            s1_man_s_q    <= 27'd0;
            s1_spec_q     <= 1'b0;
            s1_spec_res_q <= 32'd0;
            out_valid_q   <= 1'b0;
            result_q      <= 32'd0;
        end else begin
            in_vld_q      <= in_vld_d;
            a_q           <= a_d;
            b_q           <= b_d;
            s1_vld_q      <= s1_vld_d;
            s1_sign_q     <= s1_sign_d;
            s1_sub_q      <= s1_sub_d;
            s1_exp_q      <= s1_exp_d;
            s1_man_l_q    <= s1_man_l_d;
            s1_man_s_q    <= s1_man_s_d;
            s1_spec_q     <= s1_spec_d;
            s1_spec_res_q <= s1_spec_res_d;
            out_valid_q   <= out_valid_d;
            result_q      <= result_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
endmodule

// File: tb/tb_float32_adder.sv
`timescale 1ns/1ps
// Directed-vector bench for float32_adder: hand-computed sums streamed through
// a latency/valid reference, checked every cycle on the falling edge.
module tb_float32_adder;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] a, b;
    logic        out_valid;
    logic [31:0] result;

    float32_adder dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .result   (result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sum;
    } vec_t;
    vec_t vecs[20];

    int n_cmp = 0;
    int n_bad = 0;
    logic chk_en = 1'b0;
    logic [31:0] cur_exp;

    // Timing reference: expected sums travel two stages, result holds when idle
    logic        m_p0, m_p1, m_ov;
    logic [31:0] m_e0, m_e1, m_res;
    always @(posedge clk) begin
        if (rst) begin
            m_p0 <= 1'b0; m_p1 <= 1'b0; m_ov <= 1'b0; m_res <= 32'd0;
        end else begin
            m_p0 <= in_valid; m_e0 <= cur_exp;
            m_p1 <= m_p0;     m_e1 <= m_e0;
            m_ov <= m_p1;
            if (m_p1) m_res <= m_e1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            n_cmp++;
            if (out_valid !== m_ov) begin
                n_bad++;
                $display("FAIL out_valid @%0t: got %b want %b", $time, out_valid, m_ov);
            end
            n_cmp++;
            if (result !== m_res) begin
                n_bad++;
                $display("FAIL result @%0t: got %h want %h", $time, result, m_res);
            end
        end
    end

    task automatic drive(input logic v, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] e);
        @(posedge clk);
        #1;
        in_valid = v; a = x; b = y; cur_exp = e;
    endtask

    initial begin
        vecs[0]  = '{32'h3FC00000, 32'hBF800000, 32'h3F000000};
        vecs[1]  = '{32'h3F800000, 32'hBF800000, 32'h00000000};
        vecs[2]  = '{32'h3F800000, 32'h33800000, 32'h3F800000};
        vecs[3]  = '{32'h7F800000, 32'hFF800000, 32'h7FC00000};
        vecs[4]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000};
        vecs[5]  = '{32'h7FC00001, 32'h3F800000, 32'h7FC00000};
        vecs[6]  = '{32'h00400000, 32'h3F800000, 32'h3F800000};
        vecs[7]  = '{32'h00800000, 32'h80800001, 32'h80000000};
        vecs[8]  = '{32'h3F800000, 32'h33C00000, 32'h3F800001};
        vecs[9]  = '{32'h3F800001, 32'h33800000, 32'h3F800002};
        vecs[10] = '{32'hC0400000, 32'hC0800000, 32'hC0E00000};
        vecs[11] = '{32'h40000000, 32'hBF800000, 32'h3F800000};
        vecs[12] = '{32'h80000000, 32'h80000000, 32'h80000000};
        vecs[13] = '{32'h00000000, 32'h80000000, 32'h00000000};
        vecs[14] = '{32'h7F800000, 32'h3F800000, 32'h7F800000};
        vecs[15] = '{32'h40A00000, 32'hFF800000, 32'hFF800000};
        vecs[16] = '{32'h40A00000, 32'hC0A00000, 32'h00000000};
        vecs[17] = '{32'h12345678, 32'h00000000, 32'h12345678};
        vecs[18] = '{32'hFF7FFFFF, 32'hFF7FFFFF, 32'hFF800000};
        vecs[19] = '{32'h3F800000, 32'hFFC12345, 32'h7FC00000};

        // Reset held with a valid pair present: nothing may emerge
        rst = 1'b1; in_valid = 1'b1;
        a = 32'h40400000; b = 32'h40800000; cur_exp = 32'h40E00000;
        @(posedge clk);
        #1 chk_en = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Back-to-back stream with a single bubble
        for (int i = 0; i < 20; i++) begin
            if (i == 6) drive(1'b0, 32'hDEADBEEF, 32'h3F800000, 32'h0);
            drive(1'b1, vecs[i].a, vecs[i].b, vecs[i].sum);
        end
        repeat (4) drive(1'b0, 32'h0, 32'h0, 32'h0);

        // Reset pulse with two pairs in flight: both must be dropped
        drive(1'b1, 32'h40400000, 32'h40800000, 32'h40E00000);
        drive(1'b1, 32'h3FC00000, 32'hBF800000, 32'h3F000000);
        @(posedge clk);
        #1 rst = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0; in_valid = 1'b0;
        drive(1'b1, 32'hC0400000, 32'hC0800000, 32'hC0E00000);
        drive(1'b1, 32'h3F800000, 32'h33C00000, 32'h3F800001);
        repeat (5) drive(1'b0, 32'h0, 32'h0, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/float32_adder.md
Name: float32_adder

Overview:
- Pipelined IEEE-754 binary32 adder. Computes result = a + b.
- Round-to-nearest-even. Subnormals flushed to zero.
- Fixed latency of 2 clocks. Accepts one operand pair per cycle with no backpressure.
- Arithmetic leaf block in the FP datapath; the caller aligns results using out_valid.

Parameters:
- None. Format is fixed: 1 sign bit, 8 exponent bits (bias 127), 23 fraction bits.

Ports:
- clk  input  1  single clock; all state updates on its rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  a/b carry a valid operand pair this cycle
- a  input  32  operand A, binary32
- b  input  32  operand B, binary32
- out_valid  output  1  result holds the sum of the pair presented 2 cycles earlier
- result  output  32  sum, binary32, registered

Behaviour:
- Reset: while rst=1 at a clock edge, result=32'h00000000, out_valid=0, and all internal valid bits clear.
  - Operations in flight are discarded; no out_valid pulse appears for them after reset.
- Latency: a pair sampled at edge N with in_valid=1 produces out_valid=1 and result after edge N+2.
  - Throughput is 1 pair per cycle.
  - When in_valid=0, out_valid goes 0 two cycles later; result holds its last value.
- Stage 1 (unpack/align):
  - Extract sign, exponent and fraction; implicit 1 when the exponent is nonzero.
  - Exponent 0 (zero or subnormal) is treated as signed zero (DAZ).
  - Swap so the larger magnitude (by exponent, then mantissa) is operand L.
  - Right-shift the smaller mantissa by the exponent difference.
  - Keep guard, round and sticky bits; sticky = OR of all bits shifted past round.
  - Shift amounts of 26 or more leave only the sticky bit.
- Stage 2 (add/normalize/round/pack):
  - Same signs: add mantissas. A carry-out shifts right 1, exponent +1, and the shifted-out bit is ORed into sticky.
  - Opposite signs: subtract small from L. A result of 0 gives +0. Otherwise left-normalize using leading-zero count; exponent decreases by the shift.
  - Result sign = sign of L.
  - Rounding is RNE: increment when G=1 and (R|S|LSB)=1. A mantissa overflow after rounding renormalizes, exponent +1.
- Exception handling (priority order):
  - Any NaN input -> 32'h7FC00000 (canonical quiet NaN).
  - +inf + -inf -> 32'h7FC00000.
  - inf + anything else -> that inf.
  - Biased exponent >= 255 after rounding -> signed infinity (32'h7F800000 / 32'hFF800000).
  - Biased exponent <= 0 after normalization -> signed zero (FTZ).
- Zero rules:
  - (+0)+(+0) = +0.
  - (-0)+(-0) = -0.
  - (+0)+(-0) = +0.
  - x + (-x) = +0.
  - x + 0 = x, bit-exact, for normal x.
- No status flags. Inexact, overflow and underflow are not reported.

Test Plan:
- Reset with in_valid=1 asserted -> result=0 and out_valid=0 throughout reset; first out_valid appears 2 cycles after rst deasserts.
- a=32'h40400000 (3.0), b=32'h40800000 (4.0) -> 2 cycles later result=32'h40E00000 (7.0), out_valid=1.
- Cancellation and alignment:
  - a=32'h3FC00000 (1.5), b=32'hBF800000 (-1.0) -> 32'h3F000000 (0.5).
  - a=32'h3F800000, b=32'hBF800000 -> 32'h00000000.
  - a=32'h3F800000 (1.0), b=32'h33800000 (2^-24) -> 32'h3F800000 (tie, rounds to even).
- Specials:
  - a=32'h7F800000, b=32'hFF800000 -> 32'h7FC00000.
  - a=32'h7F7FFFFF, b=32'h7F7FFFFF -> 32'h7F800000.
  - a=32'h7FC00001, b=32'h3F800000 -> 32'h7FC00000.
- FTZ:
  - a=32'h00400000 (subnormal), b=32'h3F800000 -> 32'h3F800000.
  - a=32'h00800000, b=32'h80800001 -> 32'h80000000 (underflow flushed, sign kept).
- Pipeline: back-to-back pairs on consecutive cycles with one in_valid=0 bubble -> results emerge in order 2 cycles later with a matching out_valid gap; an rst pulse mid-stream -> in-flight results dropped.
